// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - 16x16 bicolour LED matrix row scanner with frame-synchronous buffer load
//
// Purpose:
//   Scans a double-colour 16x16 LED matrix one row at a time. Each row gets
//   BLANK all-off cycles (ghosting guard) followed by DWELL driven cycles.
//   Pixel data is shown only from an internal frame buffer. That buffer is
//   refreshed from the inputs at frame boundaries, so a frame is never
//   displayed half old, half new.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - asynchronous, active-low reset
//   GrnPixels   - green frame input, [row][col]
//   RedPixels   - red frame input, [row][col]
//   load        - request to capture GrnPixels/RedPixels as the next frame
//   load_ack    - one-cycle pulse in the cycle after a capture
//   row_en      - one-hot row drive, zero outside DRIVE
//   grn_col     - green column drive for the active row
//   red_col     - red column drive for the active row
//   frame_start - pulse on the first driven cycle of row 0

module led_matrix_scan #(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0][15:0] GrnPixels,
  input  logic [15:0][15:0] RedPixels,
  input  logic              load,
  output logic              load_ack,
  output logic [15:0]       row_en,
  output logic [15:0]       grn_col,
  output logic [15:0]       red_col,
  output logic              frame_start
);

  // Counter only has to reach max(DWELL, BLANK) - 1.
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_row;
  logic [3:0]        w_next_row;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_next_cnt;
  logic              r_pending;
  logic              r_load_ack;
  logic [15:0][15:0] r_buf_grn;
  logic [15:0][15:0] r_buf_red;

  logic              w_boundary;
  logic              w_capture;

  // Next-state logic and output decode.
  always_comb begin
    w_next_state = r_state;
    w_next_row   = r_row;
    w_next_cnt   = r_cnt;
    w_boundary   = 1'b0;
    row_en       = 16'h0000;
    grn_col      = 16'h0000;
    red_col      = 16'h0000;
    frame_start  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Leaving IDLE is a frame boundary, so a load present right
        // after reset release is captured before the first row is shown.
        w_next_state = S_BLANK;
        w_next_row   = 4'd0;
        w_next_cnt   = '0;
        w_boundary   = 1'b1;
      end

      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_next_state = S_DRIVE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt   = r_cnt + CW'(1);
        end
      end

      S_DRIVE: begin
        row_en      = 16'h0001 << r_row;
        grn_col     = r_buf_grn[r_row];
        red_col     = r_buf_red[r_row];
        frame_start = (r_row == 4'd0) && (r_cnt == '0);
        if (r_cnt == DWELL_LAST) begin
          w_next_state = S_BLANK;
          w_next_cnt   = '0;
          // 4-bit counter wraps 15 -> 0 naturally.
          w_next_row   = r_row + 4'd1;
          w_boundary   = (r_row == 4'd15);
        end else begin
          w_next_cnt   = r_cnt + CW'(1);
        end
      end

      default: begin
        w_next_state = S_IDLE;
        w_next_row   = 4'd0;
        w_next_cnt   = '0;
      end
    endcase
  end

  // A load seen in the boundary cycle itself is honoured directly, so it
  // never needs to pass through the pending flag.
  assign w_capture = w_boundary && (r_pending || load);
  assign load_ack  = r_load_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_row      <= 4'd0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_load_ack <= 1'b0;
      r_buf_grn  <= '0;
      r_buf_red  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_row      <= w_next_row;
      r_cnt      <= w_next_cnt;
      r_load_ack <= w_capture;
      if (w_capture) begin
        r_buf_grn <= GrnPixels;
        r_buf_red <= RedPixels;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

endmodule
